uart_rx_phy: RTL and testbench

- Serial receiver for the PMSM_DESIGN UART link: 230400 baud, 8 data bits LSB-first, even parity, 1 stop bit.
- Reassembles an 8-byte packet into two 32-bit words. Bytes 0..3 go to rd_data1_out[31:24], [23:16], [15:8], [7:0]; bytes 4..7 go to rd_data2_out in the same order.
- Presents each packet on a valid/ready handshake.
- Sits between the board RX pin and the command-decode logic. It is the mirror of the transmit PHY framing and accepts back-to-back bytes with zero inter-byte idle.

---
 rtl/uart_rx_phy.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_phy.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_phy.sv
// UART receiver for the 8E1 command link: reassembles 8-byte packets into two
// 32-bit words behind a valid/ready handshake and flags line/packet errors.
`ifndef SYS_CLK_PERIOD
`define SYS_CLK_PERIOD 10
`endif

module uart_rx_phy #(
  parameter int band_rate    = 230400,
  parameter int timeout_bits = 22
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        uart_rx_in,
  output logic [31:0] rd_data1_out,
  output logic [31:0] rd_data2_out,
  output logic        rd_data_valid_out,
  input  logic        rd_data_ready_in,
  output logic        parity_err_out,
  output logic        frame_err_out,
  output logic        timeout_err_out,
  output logic        overrun_err_out
);
  localparam int BIT_CLKS = (1000000000 / band_rate) / `SYS_CLK_PERIOD;
  localparam int TO_CLKS  = timeout_bits * BIT_CLKS;
  localparam int TW       = $clog2(BIT_CLKS);
  localparam int IW       = $clog2(TO_CLKS);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_CLKS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(BIT_CLKS / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(TO_CLKS - 1);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  state_t          state, next_state;
  logic            sync1, sync2, sync3;
  logic            rx_s, fall;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_err;
  logic [2:0]      byte_cnt;
  logic [55:0]     pkt;
  logic [IW-1:0]   idle_cnt;
  logic            timer_clr, take_bit, take_par, take_stop, start_edge;

  // Synchroniser plus one extra stage for falling-edge detection; idle is high.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      {sync1, sync2, sync3} <= 3'b111;
    end else begin
      sync1 <= uart_rx_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rx_s = sync2;
  assign fall = sync3 & ~sync2;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    timer_clr  = 1'b0;
    take_bit   = 1'b0;
    take_par   = 1'b0;
    take_stop  = 1'b0;
    start_edge = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          next_state = S_START;
          timer_clr  = 1'b1;
          start_edge = 1'b1;
        end
      end
      S_START: begin
        // Re-centre the timer on mid-bit once the start bit is confirmed.
        if (timer == T_HALF) begin
          timer_clr  = 1'b1;
          next_state = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer == T_LAST) begin
          take_bit = 1'b1;
          if (bit_cnt == 3'd7) next_state = S_PARITY;
        end
      end
      S_PARITY: begin
        if (timer == T_LAST) begin
          take_par   = 1'b1;
          next_state = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid-stop so a back-to-back start edge half a bit later is seen.
        if (timer == T_LAST) begin
          take_stop  = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)                      timer <= '0;
    else if (timer_clr)                timer <= '0;
    else if (state == S_IDLE)          timer <= '0;
    else if (timer == T_LAST)          timer <= '0;
    else                               timer <= timer + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
      par_err <= 1'b0;
    end else begin
      if (take_bit) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (take_par) par_err <= (^shreg) ^ rx_s;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt               <= '0;
      byte_cnt          <= 3'd0;
      idle_cnt          <= '0;
      rd_data1_out      <= 32'h0;
      rd_data2_out      <= 32'h0;
      rd_data_valid_out <= 1'b0;
      parity_err_out    <= 1'b0;
      frame_err_out     <= 1'b0;
      timeout_err_out   <= 1'b0;
      overrun_err_out   <= 1'b0;
    end else begin
      parity_err_out  <= 1'b0;
      frame_err_out   <= 1'b0;
      timeout_err_out <= 1'b0;
      overrun_err_out <= 1'b0;
      if (rd_data_valid_out && rd_data_ready_in) rd_data_valid_out <= 1'b0;

      if (start_edge || byte_cnt == 3'd0) idle_cnt <= '0;
      else                                idle_cnt <= idle_cnt + 1'b1;

      if (take_stop) begin
        if (!rx_s) begin
          frame_err_out <= 1'b1;
          byte_cnt      <= 3'd0;
        end else if (par_err) begin
          parity_err_out <= 1'b1;
          byte_cnt       <= 3'd0;
        end else if (byte_cnt == 3'd7) begin
          // Bytes 0..6 sit in pkt with byte 0 at the top; byte 7 is still in shreg.
          byte_cnt <= 3'd0;
          if (rd_data_valid_out) begin
            overrun_err_out <= 1'b1;
          end else begin
            rd_data1_out      <= pkt[55:24];
            rd_data2_out      <= {pkt[23:0], shreg};
            rd_data_valid_out <= 1'b1;
          end
        end else begin
          pkt      <= {pkt[47:0], shreg};
          byte_cnt <= byte_cnt + 3'd1;
        end
      end else if (state == S_IDLE && byte_cnt != 3'd0 && !start_edge &&
                   idle_cnt == I_LAST) begin
        timeout_err_out <= 1'b1;
        byte_cnt        <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_phy.sv
// Scoreboard bench for uart_rx_phy: a byte-level packet model queues expected
// packets/error pulses and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_rx_phy;
  localparam int BAND    = 6250000;   // 16 clocks per bit at 10 ns
  localparam int BIT     = 16;
  localparam int HALF    = BIT / 2;
  localparam int TO_BITS = 22;
  localparam int EV_PKT = 0, EV_PAR = 1, EV_FRM = 2, EV_TO = 3, EV_OVR = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        ready = 1'b1;
  logic [31:0] d1, d2;
  logic        valid, perr, ferr, terr, oerr;

  uart_rx_phy #(.band_rate(BAND), .timeout_bits(TO_BITS)) dut (
    .sys_clk(clk), .reset_n(reset_n), .uart_rx_in(rx),
    .rd_data1_out(d1), .rd_data2_out(d2), .rd_data_valid_out(valid),
    .rd_data_ready_in(ready), .parity_err_out(perr), .frame_err_out(ferr),
    .timeout_err_out(terr), .overrun_err_out(oerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] d1;
    logic [31:0] d2;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] m_bytes[$];
  bit         m_held = 1'b0;
  int         n_checks = 0, n_err = 0;
  int         cyc = 0, last_start = 0, pkt_start = 0, rise_cyc = 0, to_cyc = 0;
  logic [31:0] h1 = 0, h2 = 0;
  bit         await_hs = 0, prev_valid = 0, prev_hs = 0;
  logic [7:0] rb;
  int         r;
  bit         fl, st;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = k; e.d1 = a; e.d2 = b;
    exp_q.push_back(e);
  endtask

  // Reference model: one call per received frame, at packet/byte granularity.
  task automatic model_byte(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    logic [31:0] w1, w2;
    if (!stop_ok) begin
      push(EV_FRM, 0, 0); m_bytes.delete();
    end else if (!par_ok) begin
      push(EV_PAR, 0, 0); m_bytes.delete();
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 8) begin
        w1 = 0; w2 = 0;
        for (int i = 0; i < 4; i++) begin
          w1 = {w1[23:0], m_bytes[i]};
          w2 = {w2[23:0], m_bytes[i+4]};
        end
        if (m_held) push(EV_OVR, 0, 0);
        else begin
          push(EV_PKT, w1, w2);
          if (!ready) m_held = 1'b1;
        end
        m_bytes.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip, input bit stop);
    model_byte(b, !flip, stop);
    last_start = cyc;
    rx = 1'b0; repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; repeat (BIT) @(negedge clk);
    end
    rx = (^b) ^ flip; repeat (BIT) @(negedge clk);
    rx = stop;        repeat (BIT) @(negedge clk);
  endtask

  task automatic send_packet(input logic [31:0] w1, input logic [31:0] w2);
    logic [63:0] p;
    p = {w1, w2};
    pkt_start = cyc;
    for (int i = 0; i < 8; i++) send_byte(p[63-8*i -: 8], 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    if (m_bytes.size() != 0 && n + 11*BIT >= TO_BITS*BIT + 4) begin
      push(EV_TO, 0, 0); m_bytes.delete();
    end
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input bit v);
    @(posedge clk); #1 ready = v;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40*BIT) begin
      @(negedge clk); k++;
    end
    chk(exp_q.size() == 0, {name, "_drain"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check(input int kind, input string name);
    ev_t e;
    chk(exp_q.size() != 0, {name, "_expected"}, 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.kind == kind, {name, "_kind"}, kind, e.kind);
      if (kind == EV_PKT && e.kind == EV_PKT) begin
        chk(d1 == e.d1, "pkt_data1", d1, e.d1);
        chk(d2 == e.d2, "pkt_data2", d2, e.d2);
        h1 = e.d1; h2 = e.d2;
      end
    end
  endtask

  always @(negedge clk) begin
    int np;
    if (!reset_n) begin
      prev_valid = 0; prev_hs = 0; await_hs = 0;
    end else begin
      np = int'(perr) + int'(ferr) + int'(terr) + int'(oerr);
      if (np != 0) chk(np == 1, "pulse_exclusive", np, 1);
      if (prev_hs) chk(valid == 1'b0, "valid_clear", valid, 0);
      if (valid && !prev_valid) begin
        rise_cyc = cyc;
        pop_check(EV_PKT, "packet");
        await_hs = 1;
      end
      if (perr) pop_check(EV_PAR, "parity_err");
      if (ferr) pop_check(EV_FRM, "frame_err");
      if (oerr) pop_check(EV_OVR, "overrun_err");
      if (terr) begin
        to_cyc = cyc;
        pop_check(EV_TO, "timeout_err");
      end
      if (valid && ready && await_hs) begin
        chk(d1 == h1 && d2 == h2, "hs_data", {d1, d2}, {h1, h2});
        await_hs = 0;
      end
      prev_hs    = valid && ready;
      prev_valid = valid;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk(valid == 1'b0, "rst_valid", valid, 0);
    chk(d1 == 32'h0, "rst_data1", d1, 0);
    chk(d2 == 32'h0, "rst_data2", d2, 0);
    chk({perr, ferr, terr, oerr} == 4'h0, "rst_pulses", {perr, ferr, terr, oerr}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back clean packet, ready held high
    send_packet(32'h12345678, 32'h9ABCDEF0);
    drain("t1");
    chk(rise_cyc - pkt_start == 3 + HALF + 10*BIT + 77*BIT, "t1_latency",
        rise_cyc - pkt_start, 3 + HALF + 10*BIT + 77*BIT);
    idle(2*BIT);

    // Held packet overrun by a second one
    set_ready(1'b0);
    send_packet(32'h12345678, 32'h9ABCDEF0);
    send_packet(32'hA5A5A5A5, 32'h5A5A5A5A);
    drain("t2");
    chk(valid == 1'b1, "t2_held_valid", valid, 1);
    chk(d1 == 32'h12345678, "t2_held_data1", d1, 32'h12345678);
    set_ready(1'b1);
    m_held = 1'b0;
    repeat (3) @(negedge clk);
    chk(valid == 1'b0, "t2_released", valid, 0);

    // Parity error on byte 3, then a clean packet
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b1);
    send_byte(8'h04, 1'b1, 1'b1);
    idle(2*BIT);
    send_packet(32'h11223344, 32'h55667788);
    drain("t3");

    // Frame error with bad parity too: frame wins
    send_byte(8'hC3, 1'b1, 1'b0);
    idle(2*BIT);
    send_packet(32'hDEADBEEF, 32'h01234567);
    drain("t4");

    // Short low glitch is rejected as a false start
    rx = 1'b0; repeat (BIT/4) @(negedge clk);
    idle(3*BIT);
    send_packet(32'hCAFEF00D, 32'h0BADC0DE);
    drain("t5");

    // Partial packet discarded on idle timeout
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b0, 1'b1);
    idle(30*BIT);
    drain("t6");
    chk(to_cyc - last_start == 3 + TO_BITS*BIT, "t6_timeout_time",
        to_cyc - last_start, 3 + TO_BITS*BIT);
    send_packet(32'h0F1E2D3C, 32'h4B5A6978);
    drain("t6b");

    // Reset in the middle of byte 4 while a packet is held
    set_ready(1'b0);
    send_packet(32'h13579BDF, 32'h2468ACE0);
    for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i), 1'b0, 1'b1);
    rx = 1'b0; repeat (BIT) @(negedge clk);
    rx = 1'b1; repeat (HALF) @(negedge clk);
    chk(valid == 1'b1, "t7_held_before_rst", valid, 1);
    reset_n = 1'b0;
    #1;
    chk(valid == 1'b0, "t7_rst_valid", valid, 0);
    chk(d1 == 32'h0 && d2 == 32'h0, "t7_rst_data", {d1, d2}, 0);
    chk({perr, ferr, terr, oerr} == 4'h0, "t7_rst_pulses", {perr, ferr, terr, oerr}, 0);
    chk(exp_q.size() == 0, "t7_queue_at_rst", exp_q.size(), 0);
    exp_q.delete(); m_bytes.delete(); m_held = 1'b0;
    rx = 1'b1;
    repeat (2*BIT) @(negedge clk);
    reset_n = 1'b1;
    set_ready(1'b1);
    idle(2*BIT);
    send_packet(32'h89ABCDEF, 32'h76543210);
    drain("t7");

    // Randomised byte stream with occasional parity/stop faults and gaps
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 8; i++) begin
        rb = 8'($urandom);
        r  = $urandom_range(0, 15);
        fl = (r == 0);
        st = (r != 1);
        send_byte(rb, fl, st);
        idle(st ? $urandom_range(0, 3*BIT) : $urandom_range(4, 3*BIT));
      end
    end
    idle(30*BIT);
    drain("rand");

    repeat (10) @(negedge clk);
    chk(exp_q.size() == 0, "final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
